// File: rtl/cd_local_xbar_4x2.sv
// ---------------------------------------------------------------------------
// cd_local_xbar_4x2
//
// Local crossbar between four local ports and two CV ports.
//   * Request path: 4 local inputs -> 2 CV outputs, routed by flit cv_sel.
//   * Reply path:   2 CV inputs    -> 4 local outputs, routed by
//                   {src_y[0], src_x[0]}.
// Each output arbitrates among its requesters. An input fires when it holds
// the grant and the target output's ready is high. Input ready is purely
// combinational, and output valid/data are registered with one cycle of
// latency.
//
// Configuration macro: CD_XBAR_RR_ARB_EN
//   defined   -> per-output rotating-priority arbiter. The pointer starts at
//                input 0 and moves to winner+1 on every fire.
//   undefined -> fixed priority, where the lowest input index wins.
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous active-low reset
//   in_si/in_ri/in_di   local request inputs  (valid, ready, 4*DATA_W data)
//   cv_so/cv_ro/cv_do   CV request outputs    (valid, ready, 2*DATA_W data)
//   cv_si_r/cv_ri_r/cv_di_r  CV reply inputs  (valid, ready, 2*DATA_W data)
//   out_so/out_ro/out_do     local reply outputs (valid, ready, 4*DATA_W data)
// ---------------------------------------------------------------------------
module cd_local_xbar_4x2 #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          in_si,
    output logic [3:0]          in_ri,
    input  logic [4*DATA_W-1:0] in_di,
    output logic [1:0]          cv_so,
    input  logic [1:0]          cv_ro,
    output logic [2*DATA_W-1:0] cv_do,
    input  logic [1:0]          cv_si_r,
    output logic [1:0]          cv_ri_r,
    input  logic [2*DATA_W-1:0] cv_di_r,
    output logic [3:0]          out_so,
    input  logic [3:0]          out_ro,
    output logic [4*DATA_W-1:0] out_do
);

    localparam int CV_SEL_BIT = DATA_W - 2;
    localparam int SRC_X0_BIT = 40;
    localparam int SRC_Y0_BIT = 32;

    logic [3:0]      rq_dest;   // CV output index per local input
    logic [1:0][1:0] rp_dest;   // local output index per CV reply input
    logic [7:0]      rq_gnt;    // per CV output: one-hot of the firing input
    logic [7:0]      rp_gnt;    // per local output: one-hot of the firing input

    for (genvar gi = 0; gi < 4; gi++) begin : gen_rq_dec
        assign rq_dest[gi] = in_di[gi*DATA_W + CV_SEL_BIT];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : gen_rp_dec
        assign rp_dest[gi] = {cv_di_r[gi*DATA_W + SRC_Y0_BIT],
                              cv_di_r[gi*DATA_W + SRC_X0_BIT]};
    end

    // ---------------- request path: one arbiter per CV output ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rq_out
        logic [3:0]        req;
        logic [1:0]        ptr;
        logic [1:0]        win;
        logic              any;
        logic              fire;
        logic              valid_reg;
        logic [DATA_W-1:0] data_reg;

        always_comb begin
            for (int i = 0; i < 4; i++) begin
                req[i] = in_si[i] && (rq_dest[i] == 1'(gi));
            end
        end

        // Scan starting at ptr. The 2-bit sum wraps modulo the 4 inputs.
        always_comb begin
            any = 1'b0;
            win = '0;
            for (int k = 0; k < 4; k++) begin
                if (!any && req[ptr + 2'(k)]) begin
                    any = 1'b1;
                    win = ptr + 2'(k);
                end
            end
        end

        // Gating with reset keeps every ready low while reset is asserted.
        assign fire = any & cv_ro[gi] & reset;
        assign rq_gnt[gi*4 +: 4] = fire ? (4'b0001 << win) : 4'b0000;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= fire;
                if (fire) begin
                    data_reg <= in_di[win*DATA_W +: DATA_W];
                end
            end
        end

`ifdef CD_XBAR_RR_ARB_EN
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ptr <= '0;
            end else if (fire) begin
                ptr <= win + 2'd1;
            end
        end
`else
        assign ptr = '0;
`endif

        assign cv_so[gi]                 = valid_reg;
        assign cv_do[gi*DATA_W +: DATA_W] = data_reg;
    end

    // ---------------- reply path: one arbiter per local output ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : gen_rp_out
        logic [1:0]        req;
        logic              ptr;
        logic              win;
        logic              any;
        logic              fire;
        logic              valid_reg;
        logic [DATA_W-1:0] data_reg;

        always_comb begin
            for (int i = 0; i < 2; i++) begin
                req[i] = cv_si_r[i] && (rp_dest[i] == 2'(gi));
            end
        end

        always_comb begin
            any = 1'b0;
            win = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (!any && req[ptr + 1'(k)]) begin
                    any = 1'b1;
                    win = ptr + 1'(k);
                end
            end
        end

        assign fire = any & out_ro[gi] & reset;
        assign rp_gnt[gi*2 +: 2] = fire ? (2'b01 << win) : 2'b00;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= fire;
                if (fire) begin
                    data_reg <= cv_di_r[win*DATA_W +: DATA_W];
                end
            end
        end

`ifdef CD_XBAR_RR_ARB_EN
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ptr <= 1'b0;
            end else if (fire) begin
                ptr <= win + 1'b1;
            end
        end
`else
        assign ptr = 1'b0;
`endif

        assign out_so[gi]                 = valid_reg;
        assign out_do[gi*DATA_W +: DATA_W] = data_reg;
    end

    // Each input targets exactly one output, so OR-ing the per-output grants
    // gives the ready of each input.
    assign in_ri   = rq_gnt[3:0] | rq_gnt[7:4];
    assign cv_ri_r = rp_gnt[1:0] | rp_gnt[3:2] | rp_gnt[5:4] | rp_gnt[7:6];

endmodule

// File: tb/tb_cd_local_xbar_4x2.sv
// ---------------------------------------------------------------------------
// tb_cd_local_xbar_4x2
//
// Self-checking bench for cd_local_xbar_4x2.
// The directed scenarios cover reset, reply split, conflict, blocking,
// request routing, reset under traffic and rotating arbitration (when
// CD_XBAR_RR_ARB_EN is defined).
// A randomized phase is then compared against a behavioural model that
// derives grants from the routing and priority rules.
// ---------------------------------------------------------------------------
module tb_cd_local_xbar_4x2;

    logic         clk;
    logic         reset;
    logic [3:0]   in_si;
    logic [3:0]   in_ri;
    logic [255:0] in_di;
    logic [1:0]   cv_so;
    logic [1:0]   cv_ro;
    logic [127:0] cv_do;
    logic [1:0]   cv_si_r;
    logic [1:0]   cv_ri_r;
    logic [127:0] cv_di_r;
    logic [3:0]   out_so;
    logic [3:0]   out_ro;
    logic [255:0] out_do;

    int n_checks = 0;
    int n_pass   = 0;

    cd_local_xbar_4x2 #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .in_si(in_si), .in_ri(in_ri), .in_di(in_di),
        .cv_so(cv_so), .cv_ro(cv_ro), .cv_do(cv_do),
        .cv_si_r(cv_si_r), .cv_ri_r(cv_ri_r), .cv_di_r(cv_di_r),
        .out_so(out_so), .out_ro(out_ro), .out_do(out_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_ptr_rq [2];
    int          m_ptr_rp [4];
    int          n_ptr_rq [2];
    int          n_ptr_rp [4];
    logic [3:0]  e_in_ri;
    logic [1:0]  e_cv_ri;
    logic [1:0]  e_cv_so, n_cv_so;
    logic [3:0]  e_out_so, n_out_so;
    logic [63:0] e_cv_do [2];
    logic [63:0] n_cv_do [2];
    logic [63:0] e_out_do [4];
    logic [63:0] n_out_do [4];

    function automatic void model_reset();
        for (int j = 0; j < 2; j++) begin m_ptr_rq[j] = 0; e_cv_do[j] = '0; end
        for (int j = 0; j < 4; j++) begin m_ptr_rp[j] = 0; e_out_do[j] = '0; end
        e_cv_so = '0; e_out_so = '0; e_in_ri = '0; e_cv_ri = '0;
    endfunction

    // Computes this cycle's readies and the values the outputs take at the edge.
    function automatic void model_predict();
        int start, w, dst;
        e_in_ri = '0;
        e_cv_ri = '0;
        for (int j = 0; j < 2; j++) begin
            start = 0;
`ifdef CD_XBAR_RR_ARB_EN
            start = m_ptr_rq[j];
`endif
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (start + k) % 4;
                if (w < 0 && in_si[i] && int'(in_di[i*64 + 62]) == j) w = i;
            end
            n_ptr_rq[j] = m_ptr_rq[j];
            n_cv_do[j]  = e_cv_do[j];
            n_cv_so[j]  = 1'b0;
            if (w >= 0 && cv_ro[j]) begin
                e_in_ri[w]  = 1'b1;
                n_cv_so[j]  = 1'b1;
                n_cv_do[j]  = in_di[w*64 +: 64];
                n_ptr_rq[j] = (w + 1) % 4;
            end
        end
        for (int j = 0; j < 4; j++) begin
            start = 0;
`ifdef CD_XBAR_RR_ARB_EN
            start = m_ptr_rp[j];
`endif
            w = -1;
            for (int k = 0; k < 2; k++) begin
                int i;
                i = (start + k) % 2;
                dst = 2 * int'(cv_di_r[i*64 + 32]) + int'(cv_di_r[i*64 + 40]);
                if (w < 0 && cv_si_r[i] && dst == j) w = i;
            end
            n_ptr_rp[j] = m_ptr_rp[j];
            n_out_do[j] = e_out_do[j];
            n_out_so[j] = 1'b0;
            if (w >= 0 && out_ro[j]) begin
                e_cv_ri[w]  = 1'b1;
                n_out_so[j] = 1'b1;
                n_out_do[j] = cv_di_r[w*64 +: 64];
                n_ptr_rp[j] = (w + 1) % 2;
            end
        end
    endfunction

    function automatic void model_commit();
        e_cv_so  = n_cv_so;
        e_out_so = n_out_so;
        for (int j = 0; j < 2; j++) begin e_cv_do[j] = n_cv_do[j]; m_ptr_rq[j] = n_ptr_rq[j]; end
        for (int j = 0; j < 4; j++) begin e_out_do[j] = n_out_do[j]; m_ptr_rp[j] = n_ptr_rp[j]; end
    endfunction

    // Builds a flit with random vc, hop and payload fields.
    function automatic logic [63:0] mk_flit(input logic cvsel, input int sx, input int sy);
        logic [31:0] r0, r1;
        r0 = $urandom;
        r1 = $urandom;
        return {r0[31], cvsel, 6'd0, r0[7:0], 8'(sx), 8'(sy), r1};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_si = '0; cv_si_r = '0; cv_ro = 2'b11; out_ro = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset   = 1'b0;
        in_si   = 4'hF; cv_si_r = 2'b11; cv_ro = 2'b11; out_ro = 4'hF;
        in_di   = {mk_flit(0, 0, 0), mk_flit(1, 1, 0), mk_flit(0, 0, 1), mk_flit(1, 1, 1)};
        cv_di_r = {mk_flit(0, 1, 0), mk_flit(0, 0, 1)};
        #2;
        n_checks++; if (in_ri !== 4'h0) $display("FAIL reset_in_ri: got %b expected 0000", in_ri); else n_pass++;
        n_checks++; if (cv_ri_r !== 2'b00) $display("FAIL reset_cv_ri_r: got %b expected 00", cv_ri_r); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_so !== 4'h0) $display("FAIL reset_out_so: got %b expected 0000", out_so); else n_pass++;
        n_checks++; if (cv_so !== 2'b00) $display("FAIL reset_cv_so: got %b expected 00", cv_so); else n_pass++;
        n_checks++; if (out_do !== '0) $display("FAIL reset_out_do: got %h expected 0", out_do); else n_pass++;
        n_checks++; if (cv_do !== '0) $display("FAIL reset_cv_do: got %h expected 0", cv_do); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        in_si = '0; cv_si_r = '0;
        $display("test_reset done");
    endtask

    task automatic test_reply_split();
        logic [63:0] r0, r1;
        do_reset();
        r0 = mk_flit(0, 1, 0);
        r1 = mk_flit(0, 0, 1);
        cv_di_r = {r1, r0}; cv_si_r = 2'b11; out_ro = 4'hF;
        #1;
        n_checks++; if (cv_ri_r !== 2'b11) $display("FAIL split_ready: got %b expected 11", cv_ri_r); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_so !== 4'b0110) $display("FAIL split_valid: got %b expected 0110", out_so); else n_pass++;
        n_checks++; if (out_do[127:64] !== r0) $display("FAIL split_out1: got %h expected %h", out_do[127:64], r0); else n_pass++;
        n_checks++; if (out_do[191:128] !== r1) $display("FAIL split_out2: got %h expected %h", out_do[191:128], r1); else n_pass++;
        $display("test_reply_split done");
    endtask

    task automatic test_reply_conflict();
        logic [63:0] r0, r1;
        do_reset();
        r0 = mk_flit(0, 1, 0);
        r1 = mk_flit(1, 1, 0);
        cv_di_r = {r1, r0}; cv_si_r = 2'b11;
        #1;
        n_checks++; if (cv_ri_r !== 2'b01) $display("FAIL conflict_ready: got %b expected 01", cv_ri_r); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_so !== 4'b0010) $display("FAIL conflict_valid: got %b expected 0010", out_so); else n_pass++;
        n_checks++; if (out_do[127:64] !== r0) $display("FAIL conflict_out1: got %h expected %h", out_do[127:64], r0); else n_pass++;
        $display("test_reply_conflict done");
    endtask

    task automatic test_reply_blocked();
        logic [63:0] first, r0, r1;
        do_reset();
        // First load out2 with a known flit so the data hold is observable.
        first = mk_flit(0, 0, 1);
        cv_di_r = {64'd0, first}; cv_si_r = 2'b01;
        @(posedge clk);
        @(negedge clk);
        r0 = mk_flit(0, 0, 1);
        r1 = mk_flit(0, 0, 1);
        cv_di_r = {r1, r0}; cv_si_r = 2'b11; out_ro = 4'b1011;
        #1;
        n_checks++; if (cv_ri_r !== 2'b00) $display("FAIL blocked_ready: got %b expected 00", cv_ri_r); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_so !== 4'b0000) $display("FAIL blocked_valid: got %b expected 0000", out_so); else n_pass++;
        n_checks++; if (out_do[191:128] !== first) $display("FAIL blocked_hold: got %h expected %h", out_do[191:128], first); else n_pass++;
        out_ro = 4'hF;
        $display("test_reply_blocked done");
    endtask

    task automatic test_request();
        logic [63:0] p0, p1, p2, p3;
        logic [3:0]  exp_ri;
        do_reset();
        p0 = mk_flit(0, 0, 0); p1 = mk_flit(0, 1, 0);
        p2 = mk_flit(1, 0, 1); p3 = mk_flit(0, 1, 1);
        in_di = {p3, p2, p1, p0}; in_si = 4'b0101; cv_ro = 2'b11;
        #1;
        n_checks++; if (in_ri !== 4'b0101) $display("FAIL req_ready: got %b expected 0101", in_ri); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (cv_so !== 2'b11) $display("FAIL req_valid: got %b expected 11", cv_so); else n_pass++;
        n_checks++; if (cv_do[63:0] !== p0) $display("FAIL req_cv0: got %h expected %h", cv_do[63:0], p0); else n_pass++;
        n_checks++; if (cv_do[127:64] !== p2) $display("FAIL req_cv1: got %h expected %h", cv_do[127:64], p2); else n_pass++;
        @(negedge clk);
        p2 = mk_flit(0, 0, 1);
        in_di = {p3, p2, p1, p0}; in_si = 4'b1111;
        #1;
`ifdef CD_XBAR_RR_ARB_EN
        exp_ri = 4'b0010;   // cv0 pointer moved past input 0 after its fire
`else
        exp_ri = 4'b0001;
`endif
        n_checks++; if (in_ri !== exp_ri) $display("FAIL req_all_cv0: got %b expected %b", in_ri, exp_ri); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        in_si = '0;
        $display("test_request done");
    endtask

    task automatic test_reset_mid_traffic();
        logic [63:0] r0, r1;
        do_reset();
        cv_di_r = {64'd0, mk_flit(0, 1, 0)}; cv_si_r = 2'b01;   // advances out1 pointer in RR build
        @(posedge clk);
        @(negedge clk);
        cv_di_r = {mk_flit(0, 1, 1), mk_flit(0, 0, 0)}; cv_si_r = 2'b11;
        in_di[63:0] = mk_flit(0, 0, 0); in_si = 4'b0001;
        @(posedge clk); #1;
        n_checks++; if (out_so !== 4'b1001) $display("FAIL mid_pre_valid: got %b expected 1001", out_so); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (out_so !== 4'b0000) $display("FAIL mid_out_so: got %b expected 0000", out_so); else n_pass++;
        n_checks++; if (cv_so !== 2'b00) $display("FAIL mid_cv_so: got %b expected 00", cv_so); else n_pass++;
        n_checks++; if ({in_ri, cv_ri_r} !== 6'b0) $display("FAIL mid_ready: got %b expected 000000", {in_ri, cv_ri_r}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        in_si = '0;
        r0 = mk_flit(0, 1, 0);
        r1 = mk_flit(0, 1, 0);
        cv_di_r = {r1, r0}; cv_si_r = 2'b11;
        #1;
        n_checks++; if (cv_ri_r !== 2'b01) $display("FAIL mid_restart_ready: got %b expected 01", cv_ri_r); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_do[127:64] !== r0) $display("FAIL mid_restart_data: got %h expected %h", out_do[127:64], r0); else n_pass++;
        $display("test_reset_mid_traffic done");
    endtask

`ifdef CD_XBAR_RR_ARB_EN
    task automatic test_rr_alternate();
        logic [63:0] r0, r1;
        logic [1:0]  exp_ri;
        do_reset();
        r0 = mk_flit(0, 1, 0);
        r1 = mk_flit(0, 1, 0);
        cv_di_r = {r1, r0}; cv_si_r = 2'b11;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            exp_ri = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (cv_ri_r !== exp_ri) $display("FAIL rr_grant: got %b expected %b", cv_ri_r, exp_ri); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (out_do[127:64] !== ((c % 2 == 0) ? r0 : r1)) $display("FAIL rr_data: got %h", out_do[127:64]); else n_pass++;
        end
        $display("test_rr_alternate done");
    endtask
`endif

    task automatic test_random(input int n);
        logic [3:0] fired_rq;
        logic [1:0] fired_rp;
        do_reset();
        model_reset();
        fired_rq = '0; fired_rp = '0;
        for (int c = 0; c < n; c++) begin
            if (c != 0) @(negedge clk);
            // Hold any valid input that did not fire. Otherwise pick a new one.
            for (int i = 0; i < 4; i++) begin
                if (!(in_si[i] && !fired_rq[i])) begin
                    in_si[i] = ($urandom_range(0, 3) != 0);
                    in_di[i*64 +: 64] = mk_flit(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!(cv_si_r[i] && !fired_rp[i])) begin
                    cv_si_r[i] = ($urandom_range(0, 3) != 0);
                    cv_di_r[i*64 +: 64] = mk_flit(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
                end
            end
            cv_ro  = 2'($urandom);
            out_ro = 4'($urandom) | 4'($urandom);
            #1;
            model_predict();
            fired_rq = e_in_ri;
            fired_rp = e_cv_ri;
            n_checks++; if (in_ri !== e_in_ri) $display("FAIL rnd_in_ri cyc %0d: got %b expected %b", c, in_ri, e_in_ri); else n_pass++;
            n_checks++; if (cv_ri_r !== e_cv_ri) $display("FAIL rnd_cv_ri_r cyc %0d: got %b expected %b", c, cv_ri_r, e_cv_ri); else n_pass++;
            @(posedge clk); #1;
            model_commit();
            n_checks++; if (cv_so !== e_cv_so) $display("FAIL rnd_cv_so cyc %0d: got %b expected %b", c, cv_so, e_cv_so); else n_pass++;
            n_checks++; if (out_so !== e_out_so) $display("FAIL rnd_out_so cyc %0d: got %b expected %b", c, out_so, e_out_so); else n_pass++;
            for (int j = 0; j < 2; j++) begin
                n_checks++; if (cv_do[j*64 +: 64] !== e_cv_do[j]) $display("FAIL rnd_cv_do%0d cyc %0d: got %h expected %h", j, c, cv_do[j*64 +: 64], e_cv_do[j]); else n_pass++;
            end
            for (int j = 0; j < 4; j++) begin
                n_checks++; if (out_do[j*64 +: 64] !== e_out_do[j]) $display("FAIL rnd_out_do%0d cyc %0d: got %h expected %h", j, c, out_do[j*64 +: 64], e_out_do[j]); else n_pass++;
            end
        end
        $display("test_random done: %0d cycles", n);
    endtask

    initial begin
        in_si = '0; cv_si_r = '0; cv_ro = 2'b11; out_ro = 4'hF;
        in_di = '0; cv_di_r = '0; reset = 1'b0;
        test_reset();
        test_reply_split();
        test_reply_conflict();
        test_reply_blocked();
        test_request();
        test_reset_mid_traffic();
`ifdef CD_XBAR_RR_ARB_EN
        test_rr_alternate();
`endif
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cd_local_xbar_4x2.md
CD_LOCAL_XBAR_4X2 -- requirements
Module: cd_local_xbar_4x2

Interface
REQ-001 Parameter DATA_W, default 64: flit width in bits. All bit positions below assume DATA_W=64.
REQ-002 clk  in  1  single clock; all registers update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_si  in  4  request-path valid, one bit per local input port i.
REQ-005 in_ri  out  4  request-path ready, one bit per local input port.
REQ-006 in_di  in  4*DATA_W  request flits; port i occupies bits [DATA_W*(i+1)-1 : DATA_W*i].
REQ-007 cv_so / cv_ro / cv_do  out / in / out  2 / 2 / 2*DATA_W  request outputs toward the two CV ports: valid, ready, data.
REQ-008 cv_si_r / cv_ri_r / cv_di_r  in / out / in  2 / 2 / 2*DATA_W  reply inputs from the two CV ports: valid, ready, data.
REQ-009 out_so / out_ro / out_do  out / in / out  4 / 4 / 4*DATA_W  reply outputs toward the local ports: valid, ready, data; packed the same way as in_di.

Function
REQ-010 Flit fields: [63] vc; [62] cv_sel; [61] reserved; [60:56] reserved; [55:52] hop_x; [51:48] hop_y; [47:40] src_x; [39:32] src_y; [31:0] payload.
REQ-011 Reply routing: output index = {src_y[0], src_x[0]}. Examples: x0y0 goes to out0, x1y0 to out1, x0y1 to out2, x1y1 to out3.
REQ-012 Request routing: the CV output index is the cv_sel bit of the flit.
REQ-013 An input requests output j when its valid bit is 1 and its decoded destination is j.
REQ-014 Each output grants at most one requester per cycle. Default policy is fixed priority, lowest input index wins.
REQ-015 An input fires only when it is granted and the ready bit of its target output is 1.
REQ-016 Input ready (in_ri / cv_ri_r) is 1 exactly when that input fires. It is combinational from valid, data, grant and output ready.
REQ-017 A losing or blocked input sees ready=0 and must hold its valid and data stable.
REQ-018 Output valid and data are registered.
  - On each clock edge, out_so[j] / cv_so[j] is set to the fire status of output j.
  - On a fire, the data register captures the winner's flit.
  - Without a fire, data holds its value and valid clears.
  - Latency: one cycle. Throughput: one flit per output per cycle.
REQ-019 Ready is sampled before the edge. The downstream accepts every cycle in which valid=1; outputs have no stall or hold state.
REQ-020 Inputs to different destinations fire in the same cycle. The request path and the reply path operate independently.
REQ-021 If both reply inputs target an output whose ready is 0, neither fires (cv_ri_r=00) and that output's valid is 0 next cycle.

Reset
REQ-022 While reset=0: all out_so, cv_so, out_do and cv_do registers are 0, arbitration pointers are 0, and all ready outputs are 0.
REQ-023 Release is synchronous to the next clk edge. The first post-reset cycle arbitrates normally.

Configuration
REQ-024 Macro CD_XBAR_RR_ARB_EN.
  - Defined: each output uses a rotating-priority arbiter. The pointer resets to input 0 and advances to winner+1 (mod number of inputs) on each fire.
  - Undefined: fixed priority as in REQ-014.
  - The first conflict after reset is won by input 0 in both builds.

Verification
REQ-025 Reply split: cv_si_r=11, r0 = x1y0 flit, r1 = x0y1 flit, out_ro=1111 -> after one edge out_so=0110, out1=r0, out2=r1, cv_ri_r=11 before the edge.
REQ-026 Reply conflict: both reply inputs target x1y0 -> cv_ri_r=01, next out_so=0010, out1 = r0 flit.
REQ-027 Reply blocked: out_ro=1011, both reply inputs target x0y1 -> cv_ri_r=00, next out_so=0000.
REQ-028 Request path: in_si=0101, port0 cv_sel=0, port2 cv_sel=1, cv_ro=11 -> in_ri=0101, next cv_so=11 with matching data. Then with all four ports on cv0 -> in_ri=0001.
REQ-029 Reset mid-traffic: assert reset with out_so=1001 -> all valids and readies are 0 immediately; after release, arbitration restarts at input 0.
REQ-030 With CD_XBAR_RR_ARB_EN: two reply inputs contending continuously for out1 -> grants alternate r0, r1, r0.
